// File: rtl/bus_mux_pkg.sv
// bus_mux_pkg: mode encodings and select decode shared by the bus mux blocks
package bus_mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_ARB = 1'b1;
  function automatic logic [31:0] sel_onehot(input int idx, input int n);
    return (idx < n) ? (32'd1 << idx) : 32'd0;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant; round-robin with BUS_MUX_RR_EN, else fixed lowest-index priority
module rr_arbiter #(
  parameter int N = 4
) (
`ifdef BUS_MUX_RR_EN
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
`endif
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
`ifdef BUS_MUX_RR_EN
  localparam int SEL_W = $clog2(N);
  logic [SEL_W-1:0] ptr;
  int gidx;
  // Scan from lowest to highest priority so the last hit is the one nearest ptr+1.
  always_comb begin
    gnt = '0;
    gidx = 0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        gidx = (int'(ptr) + k) % N;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= SEL_W'(N - 1);
    else if (adv) ptr <= SEL_W'(gidx);
`else
  assign gnt = req & (~req + 1'b1);
`endif
endmodule

// File: rtl/bus_mux_arb.sv
// bus_mux_arb: N-channel registered bus mux, manual select or arbitrated (round-robin when BUS_MUX_RR_EN)
module bus_mux_arb
  import bus_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready
);
  logic ld, accept;
  logic [N-1:0] man_grant, arb_grant, grant;
  logic [SEL_W-1:0] gsel;
  logic [W-1:0] gdata;
  assign ld = ~out_valid | out_ready;
  assign man_grant = N'(sel_onehot(int'(sel), N)) & in_valid;
  assign grant = (mode == MODE_ARB) ? arb_grant : man_grant;
  assign in_ready = grant & {N{ld & rst_n}};
  assign accept = |in_ready;
  rr_arbiter #(.N(N)) u_arb (
`ifdef BUS_MUX_RR_EN
    .clk(clk),
    .rst_n(rst_n),
    .adv(accept & (mode == MODE_ARB)),
`endif
    .req(in_valid),
    .gnt(arb_grant)
  );
  always_comb begin
    gsel = '0;
    gdata = '0;
    for (int i = 0; i < N; i++) begin
      gsel = grant[i] ? SEL_W'(i) : gsel;
      gdata = gdata | (in_data[i*W +: W] & {W{grant[i]}});
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data <= gdata;
      out_sel <= gsel;
    end else if (out_ready) out_valid <= 1'b0;
endmodule
